// File: rtl/led_pattern_gen.sv
// LED pattern generator: a selectable-period timebase drives three patterns
// (all-LED blink, rotate-left, ping-pong) plus a one-cycle update strobe.
module led_pattern_gen #(
  parameter int     NB_LED     = 4,
  parameter int     NB_COUNTER = 32,
  parameter longint R0         = 2**23,
  parameter longint R1         = 2**24,
  parameter longint R2         = 2**25,
  parameter longint R3         = 2**26
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [1:0]        i_sel,
  output logic [NB_LED-1:0] o_led_flash,
  output logic [NB_LED-1:0] o_led_shiftreg,
  output logic [NB_LED-1:0] o_led_shift_mode,
  output logic              o_tick
);

  // Terminal counts are limit-1 so a limit of 2**NB_COUNTER still fits the counter.
  localparam logic [NB_COUNTER-1:0] LIM0 = NB_COUNTER'(R0 - 1);
  localparam logic [NB_COUNTER-1:0] LIM1 = NB_COUNTER'(R1 - 1);
  localparam logic [NB_COUNTER-1:0] LIM2 = NB_COUNTER'(R2 - 1);
  localparam logic [NB_COUNTER-1:0] LIM3 = NB_COUNTER'(R3 - 1);
  localparam logic [NB_LED-1:0]     LED_LSB = {{(NB_LED-1){1'b0}}, 1'b1};

  logic [1:0]            sel_q;
  logic [NB_COUNTER-1:0] cnt;
  logic [NB_COUNTER-1:0] limit_m1;
  logic                  dir;
  logic                  dir_next;
  logic                  sel_change;
  logic                  wrap;
  logic [NB_LED-1:0]     flash_next;
  logic [NB_LED-1:0]     shiftreg_next;
  logic [NB_LED-1:0]     shift_mode_next;

  always_comb begin
    limit_m1 = LIM0;
    case (sel_q)
      2'd0:    limit_m1 = LIM0;
      2'd1:    limit_m1 = LIM1;
      2'd2:    limit_m1 = LIM2;
      default: limit_m1 = LIM3;
    endcase
  end

  // A select change takes priority over counting and suppresses any tick.
  assign sel_change = (i_sel != sel_q);
  assign wrap       = !sel_change && i_enable && (cnt >= limit_m1);

  always_comb begin
    flash_next      = ~o_led_flash;
    shiftreg_next   = {o_led_shiftreg[NB_LED-2:0], o_led_shiftreg[NB_LED-1]};
    dir_next        = dir;
    shift_mode_next = o_led_shift_mode;
    // Bounce at the ends by reversing and stepping in the same update.
    if (!dir) begin
      if (o_led_shift_mode[NB_LED-1]) begin
        dir_next        = 1'b1;
        shift_mode_next = o_led_shift_mode >> 1;
      end else begin
        shift_mode_next = o_led_shift_mode << 1;
      end
    end else begin
      if (o_led_shift_mode[0]) begin
        dir_next        = 1'b0;
        shift_mode_next = o_led_shift_mode << 1;
      end else begin
        shift_mode_next = o_led_shift_mode >> 1;
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sel_q            <= 2'd0;
      cnt              <= '0;
      dir              <= 1'b0;
      o_tick           <= 1'b0;
      o_led_flash      <= '0;
      o_led_shiftreg   <= LED_LSB;
      o_led_shift_mode <= LED_LSB;
    end else begin
      o_tick <= wrap;
      if (sel_change) begin
        sel_q <= i_sel;
        cnt   <= '0;
      end else if (i_enable) begin
        if (wrap) cnt <= '0;
        else      cnt <= cnt + NB_COUNTER'(1);
      end
      if (wrap) begin
        o_led_flash      <= flash_next;
        o_led_shiftreg   <= shiftreg_next;
        o_led_shift_mode <= shift_mode_next;
        dir              <= dir_next;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with short periods (4/8/16/32) and 4 LEDs.
module tb_led_pattern_gen;

  logic       clock;
  logic       i_reset;
  logic       i_enable;
  logic [1:0] i_sel;
  logic [3:0] o_led_flash;
  logic [3:0] o_led_shiftreg;
  logic [3:0] o_led_shift_mode;
  logic       o_tick;

  int checks = 0;
  int errors = 0;

  led_pattern_gen #(
    .NB_LED(4), .NB_COUNTER(8), .R0(4), .R1(8), .R2(16), .R3(32)
  ) dut (
    .clock           (clock),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_sel           (i_sel),
    .o_led_flash     (o_led_flash),
    .o_led_shiftreg  (o_led_shiftreg),
    .o_led_shift_mode(o_led_shift_mode),
    .o_tick          (o_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input logic [1:0] sel);
    i_reset  = 1'b0;
    i_enable = 1'b1;
    i_sel    = sel;
    @(negedge clock);
    @(negedge clock);
    i_reset = 1'b1;
  endtask

  task automatic test_reset;
    i_reset  = 1'b0;
    i_enable = 1'b1;
    i_sel    = 2'd0;
    @(negedge clock);
    checks++;
    if ({o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick} !== {4'h0, 4'h1, 4'h1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %b/%b/%b tick=%b, want 0000/0001/0001 tick=0",
               o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick);
    end
    $display("reset: flash=%b sr=%b mode=%b tick=%b", o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick);
  endtask

  task automatic test_basic;
    logic [3:0] exp_flash [0:3];
    logic [3:0] exp_sr    [0:3];
    exp_flash = '{4'hF, 4'h0, 4'hF, 4'h0};
    exp_sr    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset(2'd0);
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        checks++;
        if (o_tick !== 1'b0) begin
          errors++;
          $display("FAIL basic_no_tick: tick %0d cycle %0d got %b want 0", t, c, o_tick);
        end
      end
      @(negedge clock);
      checks++;
      if (o_tick !== 1'b1) begin
        errors++;
        $display("FAIL basic_tick: tick %0d got %b want 1", t, o_tick);
      end
      checks++;
      if (o_led_flash !== exp_flash[t]) begin
        errors++;
        $display("FAIL basic_flash: tick %0d got %b want %b", t, o_led_flash, exp_flash[t]);
      end
      checks++;
      if (o_led_shiftreg !== exp_sr[t]) begin
        errors++;
        $display("FAIL basic_shiftreg: tick %0d got %b want %b", t, o_led_shiftreg, exp_sr[t]);
      end
      $display("basic tick %0d: flash=%b sr=%b", t, o_led_flash, o_led_shiftreg);
    end
  endtask

  task automatic test_pingpong;
    logic [3:0] exp_mode [0:11];
    exp_mode = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_reset(2'd0);
    for (int t = 0; t < 12; t++) begin
      repeat (3) @(negedge clock);
      @(negedge clock);
      checks++;
      if (o_tick !== 1'b1) begin
        errors++;
        $display("FAIL pingpong_tick: tick %0d got %b want 1", t, o_tick);
      end
      checks++;
      if (o_led_shift_mode !== exp_mode[t]) begin
        errors++;
        $display("FAIL pingpong_mode: tick %0d got %b want %b", t, o_led_shift_mode, exp_mode[t]);
      end
      $display("pingpong tick %0d: mode=%b", t, o_led_shift_mode);
    end
  endtask

  task automatic test_freeze;
    do_reset(2'd0);
    repeat (6) @(negedge clock);  // one tick, then cnt=2
    i_enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++;
      if ({o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick} !== {4'hF, 4'b0010, 4'b0010, 1'b0}) begin
        errors++;
        $display("FAIL freeze_hold: cycle %0d got %b/%b/%b tick=%b want 1111/0010/0010 tick=0",
                 c, o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick);
      end
    end
    i_enable = 1'b1;
    @(negedge clock);
    checks++;
    if (o_tick !== 1'b0) begin
      errors++;
      $display("FAIL freeze_early_tick: got %b want 0", o_tick);
    end
    @(negedge clock);
    checks++;
    if ({o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick} !== {4'h0, 4'b0100, 4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL freeze_resume: got %b/%b/%b tick=%b want 0000/0100/0100 tick=1",
               o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick);
    end
    $display("freeze resume: flash=%b sr=%b tick=%b", o_led_flash, o_led_shiftreg, o_tick);
  endtask

  task automatic test_sel_change;
    logic [3:0] exp_flash [0:1];
    logic [3:0] exp_sr    [0:1];
    exp_flash = '{4'hF, 4'h0};
    exp_sr    = '{4'b0010, 4'b0100};
    do_reset(2'd0);
    repeat (3) @(negedge clock);  // cnt=3: next edge would wrap
    i_sel = 2'd2;
    @(negedge clock);
    checks++;
    if ({o_tick, o_led_flash} !== {1'b0, 4'h0}) begin
      errors++;
      $display("FAIL sel_change_edge: got tick=%b flash=%b want tick=0 flash=0000", o_tick, o_led_flash);
    end
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c < 15; c++) begin
        @(negedge clock);
        checks++;
        if (o_tick !== 1'b0) begin
          errors++;
          $display("FAIL sel_no_tick: tick %0d cycle %0d got %b want 0", t, c, o_tick);
        end
      end
      @(negedge clock);
      checks++;
      if ({o_tick, o_led_flash, o_led_shiftreg} !== {1'b1, exp_flash[t], exp_sr[t]}) begin
        errors++;
        $display("FAIL sel_tick: tick %0d got tick=%b flash=%b sr=%b want tick=1 flash=%b sr=%b",
                 t, o_tick, o_led_flash, o_led_shiftreg, exp_flash[t], exp_sr[t]);
      end
      $display("sel2 tick %0d: flash=%b sr=%b", t, o_led_flash, o_led_shiftreg);
    end
  endtask

  task automatic test_reset_mid;
    do_reset(2'd0);
    repeat (10) @(negedge clock);  // two ticks (sr=0100), then cnt=2
    checks++;
    if (o_led_shiftreg !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid_pre: sr got %b want 0100", o_led_shiftreg);
    end
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if ({o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick} !== {4'h0, 4'h1, 4'h1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_async: got %b/%b/%b tick=%b want 0000/0001/0001 tick=0",
               o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick);
    end
    @(negedge clock);
    i_reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (o_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_tick: cycle %0d got %b want 0", c, o_tick);
      end
    end
    @(negedge clock);
    checks++;
    if ({o_tick, o_led_flash, o_led_shiftreg} !== {1'b1, 4'hF, 4'b0010}) begin
      errors++;
      $display("FAIL reset_mid_tick: got tick=%b flash=%b sr=%b want tick=1 flash=1111 sr=0010",
               o_tick, o_led_flash, o_led_shiftreg);
    end
    $display("reset_mid first tick: flash=%b sr=%b", o_led_flash, o_led_shiftreg);
  endtask

  task automatic test_sel_enable_low;
    do_reset(2'd0);
    repeat (6) @(negedge clock);  // one tick, then cnt=2
    i_enable = 1'b0;
    i_sel    = 2'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if ({o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick} !== {4'hF, 4'b0010, 4'b0010, 1'b0}) begin
        errors++;
        $display("FAIL sel_en_low_hold: cycle %0d got %b/%b/%b tick=%b want 1111/0010/0010 tick=0",
                 c, o_led_flash, o_led_shiftreg, o_led_shift_mode, o_tick);
      end
    end
    i_enable = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      checks++;
      if (o_tick !== 1'b0) begin
        errors++;
        $display("FAIL sel_en_low_no_tick: cycle %0d got %b want 0", c, o_tick);
      end
    end
    @(negedge clock);
    checks++;
    if ({o_tick, o_led_flash, o_led_shiftreg} !== {1'b1, 4'h0, 4'b0100}) begin
      errors++;
      $display("FAIL sel_en_low_tick: got tick=%b flash=%b sr=%b want tick=1 flash=0000 sr=0100",
               o_tick, o_led_flash, o_led_shiftreg);
    end
    $display("sel_en_low tick: flash=%b sr=%b", o_led_flash, o_led_shiftreg);
  endtask

  initial begin
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_sel    = 2'd0;
    test_reset();
    test_basic();
    test_pingpong();
    test_freeze();
    test_sel_change();
    test_reset_mid();
    test_sel_enable_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
